// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] ACK_OK        = 8'h06;
    localparam logic [7:0] ACK_NAK       = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LEN_HI,
        LEN_LO,
        DATA,
        CHK,
        ACK,
        DONE
    } state_t;

    // States in which the loader pulls bytes from the UART receiver.
    function automatic logic is_rx_state(input state_t s);
        return (s == SYNC) || (s == LEN_HI) || (s == LEN_LO) ||
               (s == DATA) || (s == CHK);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs four bytes MSB-first into a 32-bit word.
// Latency: word_valid pulses one cycle after the 4th byte is presented.
// Backpressure: none; the consumer must take the word in the word_valid cycle.
module word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0] count;

    // Shift bytes in, flag the word when the 4th byte lands.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count      <= 2'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_valid && (count == 2'd3);
            if (byte_valid) begin
                word  <= {word[23:0], byte_data};
                count <= count + 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a framed UART byte stream (sync, 16-bit word count, big-endian words) into imem from address 0,
// then answers ACK/NAK. Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
// Latency: one imem write the cycle after each 4th data byte; at most one byte per 2 cycles; ACK waits for tx_busy=0.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        r_data,
    input  logic              rx_ready,
    output logic              rd_uart,
    input  logic              tx_busy,
    output logic              wr_uart,
    output logic [7:0]        w_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t      state;
    state_t      state_next;
    logic        rd_prev;
    logic        take;
    logic        start_accept;
    logic [15:0] len;
    logic        len_bad;
    logic        last_word;
    logic        word_valid;
    logic [31:0] word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    // A byte is taken only if the previous cycle did not already take one,
    // so a late-falling rx_ready never causes a double read.
    assign take         = !reset && rx_ready && !rd_prev && is_rx_state(state);
    assign rd_uart      = take;
    assign start_accept = (state == IDLE) && start;

    assign len_bad   = ({len[15:8], r_data} == 16'd0) ||
                       ({1'b0, len[15:8], r_data} > MAX_WORDS);
    assign last_word = (17'(words_loaded) + 17'd1) == {1'b0, len};

    assign busy       = (state != IDLE);
    assign imem_we    = word_valid;
    assign imem_wdata = word;
    // Address tracks the written-word count; the length check keeps it in range.
    assign imem_addr  = words_loaded[ADDR_W-1:0];

    word_assembler u_word_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (start_accept),
        .byte_valid (take && (state == DATA)),
        .byte_data  (r_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus ACK/DONE strobes.
    always_comb begin
        state_next = state;
        wr_uart    = 1'b0;
        w_data     = 8'h00;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SYNC;
                end
            end
            SYNC: begin
                if (take && (r_data == SYNC_BYTE)) begin
                    state_next = LEN_HI;
                end
            end
            LEN_HI: begin
                if (take) begin
                    state_next = LEN_LO;
                end
            end
            LEN_LO: begin
                if (take) begin
                    state_next = len_bad ? ACK : DATA;
                end
            end
            DATA: begin
                if (word_valid && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = ACK;
`endif
                end
            end
            CHK: begin
`ifdef LOADER_CHECKSUM_EN
                if (take) begin
                    state_next = ACK;
                end
`else
                state_next = IDLE;
`endif
            end
            ACK: begin
                w_data = load_error ? ACK_NAK : ACK_OK;
                if (!tx_busy) begin
                    wr_uart    = !reset;
                    state_next = DONE;
                end
            end
            DONE: begin
                load_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame bookkeeping: length capture, error flag, word count, checksum.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_prev      <= 1'b0;
            len          <= 16'd0;
            load_error   <= 1'b0;
            words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum     <= 8'd0;
`endif
        end else begin
            rd_prev <= take;
            if (start_accept) begin
                load_error   <= 1'b0;
                words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
                checksum     <= 8'd0;
`endif
            end
            if (take) begin
                case (state)
                    LEN_HI: len[15:8] <= r_data;
                    LEN_LO: begin
                        len[7:0] <= r_data;
                        if (len_bad) begin
                            load_error <= 1'b1;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    DATA: checksum <= checksum ^ r_data;
                    CHK: begin
                        if (r_data != checksum) begin
                            load_error <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
            if (word_valid) begin
                words_loaded <= words_loaded + (ADDR_W+1)'(1);
            end
        end
    end

endmodule
